// File: rtl/arb_pkg.sv
// Shared definitions for the unified memory arbiter: FSM states, port ownership
// encoding and the data returned when an access is abandoned by the watchdog.
package arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } arb_state_e;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } arb_owner_e;

    localparam logic [31:0] BAD_DATA = 32'hDEADBEEF;

endpackage

// File: rtl/busy_watchdog.sv
// Counts consecutive BUSY cycles without a memory response and flags expiry
// once TIMEOUT such cycles have elapsed.
module busy_watchdog #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic clear,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT + 2);

    logic [CNT_W-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (reset || !enable || clear) begin
            count_reg <= '0;
        end else if (count_reg != CNT_W'(TIMEOUT)) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    // A genuine response in the same cycle always takes precedence over expiry.
    assign expired = enable && !clear && (count_reg == CNT_W'(TIMEOUT));

endmodule

// File: rtl/unified_mem_arbiter.sv
// Shares one single-ported, variable-latency memory between the fetch and data
// ports, with a bounded data burst so fetches cannot starve.
module unified_mem_arbiter
    import arb_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int MAX_D_BURST = 4,
    parameter int TIMEOUT     = 255
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                i_req,
    input  logic [ADDR_W-1:0]   i_addr,
    output logic                i_ack,
    output logic [DATA_W-1:0]   i_rdata,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [DATA_W/8-1:0] d_be,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    output logic                d_ack,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                stall_if,
    output logic                stall_mem,
    output logic                m_req,
    output logic                m_we,
    output logic [DATA_W/8-1:0] m_be,
    output logic [ADDR_W-1:0]   m_addr,
    output logic [DATA_W-1:0]   m_wdata,
    input  logic [DATA_W-1:0]   m_rdata,
    input  logic                m_ready,
    output logic                err_timeout
);

    localparam int DCNT_W = $clog2(MAX_D_BURST + 1);

    arb_state_e          state_reg;
    arb_owner_e          owner_reg;
    logic [DCNT_W-1:0]   dcount_reg;
    logic                i_ack_reg, d_ack_reg, err_reg;
    logic [DATA_W-1:0]   i_rdata_reg, d_rdata_reg;
    logic                m_we_reg;
    logic [DATA_W/8-1:0] m_be_reg;
    logic [ADDR_W-1:0]   m_addr_reg;
    logic [DATA_W-1:0]   m_wdata_reg;
    logic                wd_expired;
    logic                grant_d;

    // Data wins a contested grant unless it has already used up its burst.
    assign grant_d = d_req && (!i_req || (dcount_reg != DCNT_W'(MAX_D_BURST)));

    busy_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .reset   (reset),
        .enable  (state_reg == BUSY),
        .clear   (m_ready),
        .expired (wd_expired)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= IDLE;
            owner_reg   <= OWN_I;
            dcount_reg  <= '0;
            i_ack_reg   <= 1'b0;
            d_ack_reg   <= 1'b0;
            err_reg     <= 1'b0;
            i_rdata_reg <= '0;
            d_rdata_reg <= '0;
            m_we_reg    <= 1'b0;
            m_be_reg    <= '0;
            m_addr_reg  <= '0;
            m_wdata_reg <= '0;
        end else begin
            i_ack_reg <= 1'b0;
            d_ack_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (i_req || d_req) begin
                        state_reg <= BUSY;
                        if (grant_d) begin
                            owner_reg   <= OWN_D;
                            m_we_reg    <= d_we;
                            m_be_reg    <= d_be;
                            m_addr_reg  <= d_addr;
                            m_wdata_reg <= d_wdata;
                            if (!i_req) begin
                                dcount_reg <= '0;
                            end else if (dcount_reg != DCNT_W'(MAX_D_BURST)) begin
                                dcount_reg <= dcount_reg + 1'b1;
                            end
                        end else begin
                            owner_reg   <= OWN_I;
                            m_we_reg    <= 1'b0;
                            m_be_reg    <= '1;
                            m_addr_reg  <= i_addr;
                            m_wdata_reg <= '0;
                            dcount_reg  <= '0;
                        end
                    end
                end
                BUSY: begin
                    if (m_ready || wd_expired) begin
                        state_reg <= RESP;
                        if (!m_ready) begin
                            err_reg <= 1'b1;
                        end
                        if (owner_reg == OWN_D) begin
                            d_rdata_reg <= m_ready ? m_rdata : DATA_W'(BAD_DATA);
                            d_ack_reg   <= 1'b1;
                        end else begin
                            i_rdata_reg <= m_ready ? m_rdata : DATA_W'(BAD_DATA);
                            i_ack_reg   <= 1'b1;
                        end
                    end
                end
                RESP: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign m_req       = (state_reg == BUSY);
    assign m_we        = m_we_reg;
    assign m_be        = m_be_reg;
    assign m_addr      = m_addr_reg;
    assign m_wdata     = m_wdata_reg;
    assign i_ack       = i_ack_reg;
    assign d_ack       = d_ack_reg;
    assign i_rdata     = i_rdata_reg;
    assign d_rdata     = d_rdata_reg;
    assign err_timeout = err_reg;
    assign stall_if    = i_req & ~i_ack_reg;
    assign stall_mem   = d_req & ~d_ack_reg;

endmodule
